// File: rtl/sine_rom_arbiter.sv
// Round-robin arbiter that shares one registered-read sine ROM between N_REQ requesters.
// Define SINE_ARB_QUAD_EN for a quarter-wave ROM with quadrant folding on address and data.
module sine_rom_arbiter #(
  parameter int A_WIDTH = 8,
  parameter int D_WIDTH = 8,
  parameter int N_REQ   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*A_WIDTH-1:0]   addr,
  output logic [N_REQ-1:0]           gnt,
  output logic                       rom_en,
`ifdef SINE_ARB_QUAD_EN
  output logic [A_WIDTH-3:0]         rom_addr,
`else
  output logic [A_WIDTH-1:0]         rom_addr,
`endif
  input  logic [D_WIDTH-1:0]         rom_dout,
  output logic [N_REQ-1:0]           rvalid,
  output logic [D_WIDTH-1:0]         rdata
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
`ifdef SINE_ARB_QUAD_EN
  localparam int RA_W = A_WIDTH - 2;
`else
  localparam int RA_W = A_WIDTH;
`endif
  localparam logic [N_REQ-1:0] GNT_ONE = N_REQ'(1);
  localparam logic [PW-1:0]    PTR_LAST = PW'(N_REQ - 1);

  logic [PW-1:0]      ptr_q, ptr_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic               rom_en_q, rom_en_d;
  logic [RA_W-1:0]    rom_addr_q, rom_addr_d;
  logic [N_REQ-1:0]   tag_p1_q, tag_p1_d;
  logic [N_REQ-1:0]   rvalid_q, rvalid_d;
  logic [D_WIDTH-1:0] rdata_q, rdata_d;
`ifdef SINE_ARB_QUAD_EN
  logic               inv_p0_q, inv_p0_d;
  logic               inv_p1_q, inv_p1_d;
`endif

  logic [A_WIDTH-1:0] addr_arr [N_REQ];
  logic [A_WIDTH-1:0] sel_addr;
  logic               win_found;
  logic [PW-1:0]      win_idx;
  logic [PW-1:0]      cand;

`ifdef SINE_ARB_QUAD_EN
  // Quadrants 1 and 3 run the quarter wave backwards.
  function automatic logic [RA_W-1:0] rom_index(input logic [A_WIDTH-1:0] a);
    return a[A_WIDTH-2] ? ~a[A_WIDTH-3:0] : a[A_WIDTH-3:0];
  endfunction

  // Lower half-cycle is the mirror about midscale in offset binary.
  function automatic logic [D_WIDTH-1:0] reflect(input logic [D_WIDTH-1:0] d,
                                                 input logic inv);
    return inv ? ~d : d;
  endfunction
`else
  function automatic logic [RA_W-1:0] rom_index(input logic [A_WIDTH-1:0] a);
    return a;
  endfunction
`endif

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      addr_arr[i] = addr[i*A_WIDTH +: A_WIDTH];
    end
  end

  // Walk upward from the slot after the last winner, wrapping once.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = ptr_q;
    for (int i = 0; i < N_REQ; i++) begin
      cand = (cand == PTR_LAST) ? '0 : cand + 1'b1;
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_addr   = addr_arr[win_idx];
    ptr_d      = ptr_q;
    gnt_d      = '0;
    rom_en_d   = win_found;
    rom_addr_d = rom_addr_q;
    if (win_found) begin
      ptr_d      = win_idx;
      gnt_d      = GNT_ONE << win_idx;
      rom_addr_d = rom_index(sel_addr);
    end
    tag_p1_d = gnt_q;
    rvalid_d = tag_p1_q;
    rdata_d  = rdata_q;
`ifdef SINE_ARB_QUAD_EN
    inv_p0_d = win_found ? sel_addr[A_WIDTH-1] : 1'b0;
    inv_p1_d = inv_p0_q;
    if (|tag_p1_q) rdata_d = reflect(rom_dout, inv_p1_q);
`else
    if (|tag_p1_q) rdata_d = rom_dout;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q      <= PTR_LAST;
      gnt_q      <= '0;
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
      tag_p1_q   <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
`ifdef SINE_ARB_QUAD_EN
      inv_p0_q   <= 1'b0;
      inv_p1_q   <= 1'b0;
`endif
    end else begin
      // Grant stage: winner, ROM address and pointer.
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      rom_en_q   <= rom_en_d;
      rom_addr_q <= rom_addr_d;
      // Stage 1: tag rides alongside the ROM read.
      tag_p1_q   <= tag_p1_d;
      // Stage 2: ROM data captured and qualified.
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
`ifdef SINE_ARB_QUAD_EN
      inv_p0_q   <= inv_p0_d;
      inv_p1_q   <= inv_p1_d;
`endif
    end
  end

  assign gnt      = gnt_q;
  assign rom_en   = rom_en_q;
  assign rom_addr = rom_addr_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;

endmodule

// File: tb/tb_sine_rom_arbiter.sv
// Bench for sine_rom_arbiter: queue-based reference model plus directed vectors.
module tb_sine_rom_arbiter;

  localparam int A_WIDTH = 8;
  localparam int D_WIDTH = 8;
  localparam int N_REQ   = 4;
`ifdef SINE_ARB_QUAD_EN
  localparam int RA_W = A_WIDTH - 2;
`else
  localparam int RA_W = A_WIDTH;
`endif

  logic                     clk;
  logic                     rst;
  logic [N_REQ-1:0]         req;
  logic [N_REQ*A_WIDTH-1:0] addr;
  logic [N_REQ-1:0]         gnt;
  logic                     rom_en;
  logic [RA_W-1:0]          rom_addr;
  logic [D_WIDTH-1:0]       rom_dout;
  logic [N_REQ-1:0]         rvalid;
  logic [D_WIDTH-1:0]       rdata;

  int n_vec = 0;
  int n_err = 0;

  sine_rom_arbiter #(.A_WIDTH(A_WIDTH), .D_WIDTH(D_WIDTH), .N_REQ(N_REQ)) dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .gnt(gnt), .rom_en(rom_en),
    .rom_addr(rom_addr), .rom_dout(rom_dout), .rvalid(rvalid), .rdata(rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [D_WIDTH-1:0] rom_val(input logic [RA_W-1:0] a);
    logic [D_WIDTH-1:0] w;
    w = '0;
    w[RA_W-1:0] = a;
    return w ^ 8'hBF;
  endfunction

  // Synchronous-read ROM: data appears the cycle after the enable.
  initial rom_dout = '0;
  always @(posedge clk) if (rom_en) rom_dout <= rom_val(rom_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model
  typedef struct {
    int                 k;
    logic [D_WIDTH-1:0] data;
    int                 due;
  } rd_t;

  rd_t                pend[$];
  int                 cyc = 0;
  int                 m_ptr = N_REQ - 1;
  logic [N_REQ-1:0]   m_gnt = '0;
  logic               m_rom_en = 1'b0;
  logic [RA_W-1:0]    m_rom_addr = '0;
  logic [N_REQ-1:0]   m_rvalid = '0;
  logic [D_WIDTH-1:0] m_rdata = '0;

  function automatic logic [RA_W-1:0] exp_rom_addr(input logic [A_WIDTH-1:0] a);
`ifdef SINE_ARB_QUAD_EN
    int q;
    q = int'(a[7:6]);
    return (q == 1 || q == 3) ? ~a[5:0] : a[5:0];
`else
    return a;
`endif
  endfunction

  function automatic logic [D_WIDTH-1:0] exp_sample(input logic [A_WIDTH-1:0] a);
`ifdef SINE_ARB_QUAD_EN
    int q;
    q = int'(a[7:6]);
    return (q >= 2) ? 8'hFF - rom_val(exp_rom_addr(a)) : rom_val(exp_rom_addr(a));
`else
    return rom_val(a);
`endif
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ptr      = N_REQ - 1;
      m_gnt      = '0;
      m_rom_en   = 1'b0;
      m_rom_addr = '0;
      m_rvalid   = '0;
      m_rdata    = '0;
      pend.delete();
    end else begin
      bit found;
      int k;
      logic [1:0] ci;
      logic [A_WIDTH-1:0] a;
      rd_t e;
      m_rvalid = '0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        m_rvalid = 4'(1) << pend[0].k;
        m_rdata  = pend[0].data;
        void'(pend.pop_front());
      end
      found = 1'b0;
      k = 0;
      for (int j = 1; j <= N_REQ; j++) begin
        ci = 2'((m_ptr + j) % N_REQ);
        if (!found && req[ci]) begin
          found = 1'b1;
          k = int'(ci);
        end
      end
      m_gnt    = '0;
      m_rom_en = found;
      if (found) begin
        a          = addr[k*A_WIDTH +: A_WIDTH];
        m_gnt      = 4'(1) << k;
        m_rom_addr = exp_rom_addr(a);
        m_ptr      = k;
        e.k = k; e.data = exp_sample(a); e.due = cyc + 2;
        pend.push_back(e);
      end
      cyc++;
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    chk("gnt", 32'(gnt), 32'(m_gnt));
    chk("rom_en", 32'(rom_en), 32'(m_rom_en));
    chk("rom_addr", 32'(rom_addr), 32'(m_rom_addr));
    chk("rvalid", 32'(rvalid), 32'(m_rvalid));
    chk("rdata", 32'(rdata), 32'(m_rdata));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [3:0] pats [8] = '{4'b0110, 4'b1001, 4'b1111, 4'b0101,
                           4'b0011, 4'b1100, 4'b0001, 4'b1110};

  initial begin
    rst  = 1'b0;
    req  = 4'b1111;
    addr = {8'h93, 8'h72, 8'h51, 8'h30};

    // Reset / idle
    repeat (3) begin
      tick();
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_rvalid", 32'(rvalid), 32'h0);
    end
    rst = 1'b1;
    req = '0;
    repeat (2) tick();
    chk("idle_rom_en", 32'(rom_en), 32'h0);
    chk("idle_rdata", 32'(rdata), 32'h0);

    // Single requester
    req = 4'b0100;
    addr[2*A_WIDTH +: A_WIDTH] = 8'h40;
    tick();
    chk("single_gnt", 32'(gnt), 32'h4);
`ifndef SINE_ARB_QUAD_EN
    chk("single_rom_addr", 32'(rom_addr), 32'h40);
`endif
    req = '0;
    tick();
    chk("single_rvalid_early", 32'(rvalid), 32'h0);
    tick();
    chk("single_rvalid", 32'(rvalid), 32'h4);
`ifndef SINE_ARB_QUAD_EN
    chk("single_rdata", 32'(rdata), 32'hFF);
`endif
    tick();
    chk("single_rvalid_once", 32'(rvalid), 32'h0);

    // Round-robin fairness from a fresh pointer
    rst = 1'b0;
    tick();
    rst = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rr_gnt", 32'(gnt), 32'(1) << (i % 4));
    end
    req = '0;
    tick();
    chk("rr_rvalid_tail", 32'(rvalid), 32'h4);
    tick();
    chk("rr_rvalid_last", 32'(rvalid), 32'h8);
    tick();

    // Wrap and skip
    req = 4'b0010;
    tick();
    chk("ws_gnt1", 32'(gnt), 32'h2);
    req = 4'b0001;
    tick();
    chk("ws_wrap", 32'(gnt), 32'h1);
    req = 4'b1011;
    tick();
    chk("ws_a", 32'(gnt), 32'h2);
    tick();
    chk("ws_b", 32'(gnt), 32'h8);
    tick();
    chk("ws_c", 32'(gnt), 32'h1);
    req = '0;
    repeat (3) tick();

    // Reset mid-flight
    req = 4'b1000;
    addr[3*A_WIDTH +: A_WIDTH] = 8'h10;
    tick();
    chk("mf_gnt", 32'(gnt), 32'h8);
`ifndef SINE_ARB_QUAD_EN
    chk("mf_rom_addr", 32'(rom_addr), 32'h10);
`endif
    req = '0;
    tick();
    rst = 1'b0;
    tick();
    chk("mf_no_rvalid", 32'(rvalid), 32'h0);
    rst = 1'b1;
    req = 4'b1010;
    tick();
    chk("mf_first_gnt", 32'(gnt), 32'h2);
    chk("mf_no_rvalid2", 32'(rvalid), 32'h0);
    tick();
    chk("mf_second_gnt", 32'(gnt), 32'h8);
    req = '0;
    repeat (3) tick();

`ifdef SINE_ARB_QUAD_EN
    // Quadrant folding
    req = 4'b0001;
    addr[0 +: A_WIDTH] = 8'h45;
    tick();
    chk("quad_rom_addr_q1", 32'(rom_addr), 32'h3A);
    addr[0 +: A_WIDTH] = 8'hC5;
    tick();
    chk("quad_rom_addr_q3", 32'(rom_addr), 32'h3A);
    req = '0;
    tick();
    chk("quad_rdata_q1", 32'(rdata), 32'(rom_val(6'h3A)));
    tick();
    chk("quad_rdata_q3", 32'(rdata), 32'(~rom_val(6'h3A)));
    repeat (2) tick();
`endif

    // Mixed request patterns with shifting addresses
    for (int i = 0; i < 8; i++) begin
      req = pats[i];
      addr = addr + {8'h17, 8'h2B, 8'h3D, 8'h4F};
      tick();
    end
    req = '0;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
